sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised synchronous FIFO with valid/ready handshakes on both sides, occupancy count, almost-full flag, flush and a sticky overflow-attempt flag. It is the general-purpose buffer for decoupling pipeline stages in the core, such as fetch-to-decode and LSU request queues, and replaces the fixed 4-bit, fixed-depth queue. Storage is flop-based and the read side is registered; an optional fall-through bypass is compiled in by macro.

## Interface
Parameters:
- WIDTH, 32, data width in bits, ≥1
- DEPTH, 8, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-1, almost_full_o asserts when count ≥ AF_THRESH; range 1..DEPTH
- CNT_W, $clog2(DEPTH)+1, derived width of count_o; not overridden

Ports (reset rst_i, asynchronous, active-high; clock clk_i):
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  synchronous clear of contents
- in_valid_i  in  1  producer has data
- in_ready_o  out  1  FIFO accepts data; equals ~full_o
- in_data_i  in  WIDTH  write data
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  consumer takes head
- out_data_o  out  WIDTH  head entry data
- count_o  out  CNT_W  current occupancy, 0..DEPTH
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- almost_full_o  out  1  count_o ≥ AF_THRESH
- ovf_o  out  1  sticky: push attempted while full

## Operation
- Pointers: head (write) and tail (read), each {wrap flag, PTR_W=$clog2(DEPTH) index}. Increment wraps index DEPTH-1→0 and toggles flag.
- Empty when pointers are equal. Full when flags differ and indices are equal. count_o = head − tail, computed modulo 2·DEPTH in CNT_W bits.
- Push = in_valid_i & in_ready_o: writes mem[head.idx] and increments head.
- Pop = out_valid_o & out_ready_i: increments tail.
- out_valid_o = ~empty_o. out_data_o = mem[tail.idx], read combinationally from flop storage.
- Simultaneous push and pop when neither full nor empty: both occur and count is unchanged.
- Full: in_ready_o=0 even if out_ready_i=1, so there is no combinational ready path. A pop occurs and the push is refused.
- Empty: the pop is ignored; out_valid_o=0 and out_data_o is don't-care.
- in_valid_i & full: no write. ovf_o sets and stays set until rst_i or flush_i.
- flush_i: both pointers go to 0 and ovf_o clears. flush_i has priority over a same-cycle push or pop, and that push/pop is dropped. mem is not cleared.
- Reset: mem contents are not reset (no reset on data flops).

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, count_o=0, full_o=0, empty_o=1, almost_full_o=0, ovf_o=0. out_data_o is undefined.
- Write-to-read latency is 1 cycle. Data pushed at edge N is visible with out_valid_o=1 in the cycle after edge N.
- All status outputs (count/full/empty/almost_full/ovf) update on the edge following the causing event. They are pure functions of registers.
- rst_i asserted mid-operation clears pointers and ovf immediately (asynchronous). Any in-flight handshake in that cycle is lost.

## Configuration
- SYNC_FIFO_FALLTHROUGH_EN defined:
  - When empty and in_valid_i=1, out_valid_o=1 and out_data_o=in_data_i combinationally.
  - If out_ready_i=1 in that cycle, the word passes through: no write, no pointer change, count stays 0.
  - If out_ready_i=0, the word is written normally.
  - empty_o and count_o remain register-based and reflect storage only.
- Undefined: out_valid_o is strictly ~empty_o with 1-cycle latency as above, and there is no combinational in→out path.

## Structure
- liang_pkg holds fifo_status_t (packed: full, empty, almost_full, ovf) for consumers that bundle status. It also holds the function fifo_ptr_next(flag, idx, depth) used by both pointers.
- One sub-module, fifo_ptr: parametrised {flag, idx} register with inc_i, clr_i and asynchronous reset. It is instantiated twice, for head and tail.
- Storage is a packed array [DEPTH-1:0][WIDTH-1:0] inside sync_fifo.

## Test plan
- Reset: assert rst_i mid-stream after 3 pushes → count_o=0, empty_o=1, in_ready_o=1, ovf_o=0 immediately, before any clock edge.
- Fill/drain (DEPTH=8, WIDTH=32): push 0xA0..0xA7 → full_o=1, in_ready_o=0, almost_full_o=1 from count 7. Pop 8 times → data 0xA0..0xA7 in order, then empty_o=1.
- Wrap-around: push 5, pop 5, push 8, pop 8 → order preserved across the index wrap, full_o correct with flags differing.
- Simultaneous: with count=4, push and pop every cycle for 20 cycles → count_o stays 4 and data order is preserved. With full, pop+push → count 7, push refused, ovf_o=1 and sticky.
- Flush: count=6 and ovf_o=1, assert flush_i together with a push → count_o=0, ovf_o=0, and the pushed word is absent.
- Fall-through (macro defined): empty, in_valid_i=1, in_data_i=0x55, out_ready_i=1 → out_data_o=0x55 same cycle and count_o stays 0. Same stimulus without the macro → out_valid_o=0 that cycle and 0x55 appears one cycle later.

Source files
------------

// File: rtl/liang_pkg.sv
//==============================================================================
// Module  : liang_pkg
// Purpose : Shared types and helpers for the sync_fifo buffer family.
//           - fifo_status_t : bundled status flags for consumers that want them
//           - fifo_ptr_t    : {wrap flag, index} pointer value
//           - fifo_ptr_next : pointer increment with index wrap and flag toggle
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package liang_pkg;

    // Widest pointer index the helper handles; covers any practical depth.
    localparam int PTR_MAX_W = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic ovf;
    } fifo_status_t;

    typedef struct packed {
        logic                 flag;
        logic [PTR_MAX_W-1:0] idx;
    } fifo_ptr_t;

    // Advance a pointer: index wraps depth-1 -> 0 and the wrap flag toggles.
    function automatic fifo_ptr_t fifo_ptr_next(
        input logic                 flag,
        input logic [PTR_MAX_W-1:0] idx,
        input int unsigned          depth
    );
        fifo_ptr_t nxt;
        if (idx == PTR_MAX_W'(depth - 1)) begin
            nxt.flag = ~flag;
            nxt.idx  = '0;
        end else begin
            nxt.flag = flag;
            nxt.idx  = idx + 1'b1;
        end
        return nxt;
    endfunction

endpackage : liang_pkg

`default_nettype wire

// File: rtl/fifo_ptr.sv
//==============================================================================
// Module  : fifo_ptr
// Purpose : {wrap flag, index} pointer register for a power-of-two FIFO.
//           Clear has priority over increment.
// Ports   : clk_i  - clock
//           rst_i  - asynchronous active-high reset (pointer -> 0)
//           clr_i  - synchronous clear (pointer -> 0)
//           inc_i  - advance pointer by one entry
//           flag_o - wrap flag
//           idx_o  - entry index, $clog2(DEPTH) bits
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_ptr
    import liang_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     inc_i,
    output logic                     flag_o,
    output logic [$clog2(DEPTH)-1:0] idx_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fifo_ptr_t nxt;

    always_comb begin
        nxt = fifo_ptr_next(flag_o, PTR_MAX_W'(idx_o), unsigned'(DEPTH));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flag_o <= 1'b0;
            idx_o  <= '0;
        end else if (clr_i) begin
            flag_o <= 1'b0;
            idx_o  <= '0;
        end else if (inc_i) begin
            flag_o <= nxt.flag;
            idx_o  <= nxt.idx[PTR_W-1:0];
        end
    end

    // The helper works at the package-wide width; the upper index bits are
    // always zero here and deliberately dropped.
    generate
        if (PTR_W < PTR_MAX_W) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^nxt.idx[PTR_MAX_W-1:PTR_W];
        end
    endgenerate

endmodule : fifo_ptr

`default_nettype wire

// File: rtl/sync_fifo.sv
//==============================================================================
// Module  : sync_fifo
// Purpose : Parametrised synchronous FIFO, flop storage, valid/ready on both
//           sides, occupancy count, almost-full, flush and sticky overflow flag.
// Macro   : SYNC_FIFO_FALLTHROUGH_EN - when defined, an empty FIFO presents
//           in_data_i combinationally and a same-cycle consumer takes it
//           without it being stored.
// Ports   : clk_i, rst_i (async, active-high), flush_i (sync clear)
//           in_valid_i / in_ready_o / in_data_i    - write side
//           out_valid_o / out_ready_i / out_data_o - read side
//           count_o, full_o, empty_o, almost_full_o, ovf_o - status
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_fifo
    import liang_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             ovf_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    logic             head_flag;
    logic [PTR_W-1:0] head_idx;
    logic             tail_flag;
    logic [PTR_W-1:0] tail_idx;

    logic             push;
    logic             pop;
    logic             bypass;
    logic             ovf;
    logic [CNT_W-1:0] count;
    fifo_status_t     status;

    // Extra wrap flag bit makes the subtraction naturally modulo 2*DEPTH.
    assign count = {head_flag, head_idx} - {tail_flag, tail_idx};

    assign status.empty       = ({head_flag, head_idx} == {tail_flag, tail_idx});
    assign status.full        = (head_flag != tail_flag) && (head_idx == tail_idx);
    assign status.almost_full = (count >= CNT_W'(AF_THRESH));
    assign status.ovf         = ovf;

`ifdef SYNC_FIFO_FALLTHROUGH_EN
    // Empty FIFO forwards the incoming word; if it is consumed immediately
    // it never touches storage.
    assign bypass      = status.empty & in_valid_i & out_ready_i;
    assign out_valid_o = ~status.empty | in_valid_i;
    assign out_data_o  = status.empty ? in_data_i : mem[tail_idx];
`else
    assign bypass      = 1'b0;
    assign out_valid_o = ~status.empty;
    assign out_data_o  = mem[tail_idx];
`endif

    // Flush wins over any same-cycle handshake. Pop is qualified by stored
    // occupancy so a bypassed word never moves the tail.
    assign push = in_valid_i & ~status.full & ~bypass & ~flush_i;
    assign pop  = ~status.empty & out_ready_i & ~flush_i;

    fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_head (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (flush_i),
        .inc_i  (push),
        .flag_o (head_flag),
        .idx_o  (head_idx)
    );

    fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_tail (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (flush_i),
        .inc_i  (pop),
        .flag_o (tail_flag),
        .idx_o  (tail_idx)
    );

    // Data flops carry no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[head_idx] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf <= 1'b0;
        end else if (flush_i) begin
            ovf <= 1'b0;
        end else if (in_valid_i & status.full) begin
            ovf <= 1'b1;
        end
    end

    assign in_ready_o    = ~status.full;
    assign count_o       = count;
    assign full_o        = status.full;
    assign empty_o       = status.empty;
    assign almost_full_o = status.almost_full;
    assign ovf_o         = status.ovf;

endmodule : sync_fifo

`default_nettype wire

// File: tb/tb_sync_fifo.sv
//==============================================================================
// Module  : tb_sync_fifo
// Purpose : Self-checking bench for sync_fifo (WIDTH=32, DEPTH=8). A queue
//           model of the FIFO contents predicts status and read data; the
//           bypass behaviour follows SYNC_FIFO_FALLTHROUGH_EN when defined.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sync_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             ovf;

    sync_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty),
        .almost_full_o (almost_full),
        .ovf_o         (ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected FIFO contents, oldest first, and expected sticky overflow.
    logic [WIDTH-1:0] exp_q[$];
    logic             ovf_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: inputs change just after the rising edge, so at
    // the falling edge both the current state and the inputs about to be
    // sampled are stable.
    always @(negedge clk) begin : mon
        int               sz;
        logic             exp_valid;
        logic             pass_thru;
        logic [WIDTH-1:0] exp_data;
        sz = exp_q.size();
        if (rst) begin
            check("rst_count", 32'(count), 32'd0);
            check("rst_empty", 32'(empty), 32'd1);
            check("rst_full", 32'(full), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_ovf", 32'(ovf), 32'd0);
            exp_q.delete();
            ovf_m = 1'b0;
        end else begin
            check("count", 32'(count), 32'(sz));
            check("empty", 32'(empty), 32'(sz == 0));
            check("full", 32'(full), 32'(sz == DEPTH));
            check("almost_full", 32'(almost_full), 32'(sz >= AF));
            check("in_ready", 32'(in_ready), 32'(sz < DEPTH));
            check("ovf", 32'(ovf), 32'(ovf_m));
`ifdef SYNC_FIFO_FALLTHROUGH_EN
            exp_valid = (sz > 0) || in_valid;
            pass_thru = (sz == 0) && in_valid && out_ready && !flush;
`else
            exp_valid = (sz > 0);
            pass_thru = 1'b0;
`endif
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid && out_ready) begin
                exp_data = (sz > 0) ? exp_q[0] : in_data;
                check("out_data", out_data, exp_data);
            end
            // Predict the effect of the coming rising edge.
            if (flush) begin
                exp_q.delete();
                ovf_m = 1'b0;
            end else begin
                if (in_valid && sz == DEPTH) ovf_m = 1'b1;
                if (out_ready && sz > 0) void'(exp_q.pop_front());
                if (in_valid && sz < DEPTH && !pass_thru) exp_q.push_back(in_data);
            end
        end
    end

    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Three pushes, then an asynchronous reset with no clock edge.
        for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill to full, attempt one extra push, then drain.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'(32'hA0 + i), 1'b0, 1'b0);
        cyc(1'b1, 32'hBAD, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Wrap-around: push 5, pop 5, push 8, pop 8.
        for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous push/pop at count 4, then pop+push while full.
        for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        cyc(1'b1, $urandom, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Count 6 with ovf set, flush together with a push.
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 32'hDEAD, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, 32'h77, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Empty FIFO, word offered with consumer ready.
        cyc(1'b1, 32'h55, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Random traffic: a fill-biased phase, then a drain-biased phase.
        for (int i = 0; i < 250; i++)
            cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 40) == 0));
        for (int i = 0; i < 250; i++)
            cyc(1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 40) == 0));

        cyc(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sync_fifo

`default_nettype wire
